// File: rtl/ii_pkg.sv
// rtl/ii_pkg.sv - shared definitions for the streaming integral-image calculator
//
// Purpose: frame-size defaults, output-width derivation helpers, the FSM state
// type and the pyramid level size tables used by every instance.
// Ports: none (package).
package ii_pkg;

  localparam int MAX_WIDTH_DEF  = 320;
  localparam int MAX_HEIGHT_DEF = 240;
  localparam int PIX_W_DEF      = 8;
  localparam int NUM_LEVELS     = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ii_state_t;

  // Smallest integral width that cannot wrap for a full frame of maximum pixels.
  function automatic int ii_width(input int pix_w, input int max_w, input int max_h);
    return pix_w + $clog2(max_w * max_h);
  endfunction

  // Same for the squared path: each term is up to 2*pix_w bits wide.
  function automatic int iisq_width(input int pix_w, input int max_w, input int max_h);
    return 2 * pix_w + $clog2(max_w * max_h);
  endfunction

  // Pyramid level sizes, roughly 1/1.2 scaling per level from 320x240.
  function automatic int level_width(input int level);
    case (level)
      0:       return 320;
      1:       return 266;
      2:       return 222;
      3:       return 185;
      4:       return 154;
      5:       return 128;
      6:       return 107;
      7:       return 89;
      8:       return 74;
      9:       return 62;
      10:      return 51;
      default: return 43;
    endcase
  endfunction

  function automatic int level_height(input int level);
    case (level)
      0:       return 240;
      1:       return 200;
      2:       return 166;
      3:       return 138;
      4:       return 115;
      5:       return 96;
      6:       return 80;
      7:       return 66;
      8:       return 55;
      9:       return 46;
      10:      return 38;
      default: return 32;
    endcase
  endfunction

endpackage

// File: rtl/ii_line_buffer.sv
// rtl/ii_line_buffer.sv - one-row store of integral and squared-integral values
//
// Purpose: holds the previous row's ii / iisq per column so the current row can
// add the value directly above it.
// Ports:
//   clock    - clock
//   wr_en    - write the entry at addr (one accepted pixel)
//   addr     - column; read and write share it
//   wr_ii    - integral value to store
//   wr_iisq  - squared-integral value to store
//   rd_ii    - combinational read of the integral value at addr
//   rd_iisq  - combinational read of the squared-integral value at addr
module ii_line_buffer
  import ii_pkg::*;
#(
  parameter  int DEPTH  = MAX_WIDTH_DEF,
  parameter  int II_W   = 25,
  parameter  int IISQ_W = 33,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     addr,
  input  logic [II_W-1:0]   wr_ii,
  input  logic [IISQ_W-1:0] wr_iisq,
  output logic [II_W-1:0]   rd_ii,
  output logic [IISQ_W-1:0] rd_iisq
);

  // No reset: row 0 never reads the array, so contents before the first
  // write are irrelevant.
  logic [II_W-1:0]   mem_ii   [DEPTH];
  logic [IISQ_W-1:0] mem_iisq [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_ii[addr]   <= wr_ii;
      mem_iisq[addr] <= wr_iisq;
    end
  end

  // Read-before-write: the value read in the accepting cycle is the row above.
  assign rd_ii   = mem_ii[addr];
  assign rd_iisq = mem_iisq[addr];

endmodule

// File: rtl/stream_int_img_calc.sv
// rtl/stream_int_img_calc.sv - streaming integral / squared-integral image calculator
//
// Purpose: accepts one pixel per handshake in raster order and emits the
// inclusive integral and squared-integral value for that pixel one cycle later.
// Frame size and sq_en are latched on the first pixel of each frame.
// Ports:
//   clock, reset          - clock, asynchronous active-high reset
//   cfg_width/cfg_height  - frame size, sampled at frame start
//   sq_en                 - enable squared path, sampled at frame start
//   in_valid/in_ready/in_pix             - pixel input handshake
//   out_valid/out_ready                  - output handshake
//   out_ii/out_iisq/out_row/out_col      - result and its position
//   out_sof/out_eol/out_eof              - frame/line markers of the output
//   busy                                 - frame in progress
//   cfg_err                              - configuration invalid while idle
module stream_int_img_calc
  import ii_pkg::*;
#(
  parameter int MAX_WIDTH  = MAX_WIDTH_DEF,
  parameter int MAX_HEIGHT = MAX_HEIGHT_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int II_W       = ii_width(PIX_W, MAX_WIDTH, MAX_HEIGHT),
  parameter int IISQ_W     = iisq_width(PIX_W, MAX_WIDTH, MAX_HEIGHT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       cfg_width,
  input  logic [15:0]       cfg_height,
  input  logic              sq_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [II_W-1:0]   out_ii,
  output logic [IISQ_W-1:0] out_iisq,
  output logic [15:0]       out_row,
  output logic [15:0]       out_col,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              cfg_err
);

  localparam int          AW      = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [15:0] MAX_W16 = 16'(MAX_WIDTH);
  localparam logic [15:0] MAX_H16 = 16'(MAX_HEIGHT);

  ii_state_t           state;
  logic [15:0]         width_q;
  logic [15:0]         height_q;
  logic                sq_q;
  logic [15:0]         col_q;
  logic [15:0]         row_q;
  logic [II_W-1:0]     row_sum_q;
  logic [IISQ_W-1:0]   row_sq_q;

  logic                cfg_ok;
  logic                accept;
  logic [15:0]         eff_width;
  logic [15:0]         eff_height;
  logic                eff_sq;
  logic                last_col;
  logic                last_row;
  logic [2*PIX_W-1:0]  pix_sq;
  logic [IISQ_W-1:0]   sq_term;
  logic [II_W-1:0]     row_sum_next;
  logic [IISQ_W-1:0]   row_sq_next;
  logic [II_W-1:0]     ii_next;
  logic [IISQ_W-1:0]   iisq_next;
  logic [II_W-1:0]     lb_ii;
  logic [IISQ_W-1:0]   lb_iisq;

  assign cfg_ok = (cfg_width != 16'd0) && (cfg_width <= MAX_W16) &&
                  (cfg_height != 16'd0) && (cfg_height <= MAX_H16);

  // Ready is gated by reset so nothing can be accepted while it is asserted.
  always_comb begin
    in_ready = 1'b0;
    cfg_err  = 1'b0;
    if (!reset) begin
      if (state == ST_IDLE) begin
        cfg_err  = !cfg_ok;
        in_ready = cfg_ok && (!out_valid || out_ready);
      end else begin
        in_ready = !out_valid || out_ready;
      end
    end
  end

  assign accept = in_valid && in_ready;

  // The first pixel of a frame is processed with the live config, which is
  // also what gets latched for the rest of the frame.
  assign eff_width  = (state == ST_IDLE) ? cfg_width  : width_q;
  assign eff_height = (state == ST_IDLE) ? cfg_height : height_q;
  assign eff_sq     = (state == ST_IDLE) ? sq_en      : sq_q;

  assign last_col = (col_q == eff_width - 16'd1);
  assign last_row = (row_q == eff_height - 16'd1);

  assign pix_sq  = {{PIX_W{1'b0}}, in_pix} * {{PIX_W{1'b0}}, in_pix};
  assign sq_term = eff_sq ? IISQ_W'(pix_sq) : '0;

  assign row_sum_next = ((col_q == 16'd0) ? '0 : row_sum_q) + II_W'(in_pix);
  assign row_sq_next  = ((col_q == 16'd0) ? '0 : row_sq_q) + sq_term;
  assign ii_next      = row_sum_next + ((row_q == 16'd0) ? '0 : lb_ii);
  assign iisq_next    = row_sq_next + ((row_q == 16'd0) ? '0 : lb_iisq);

  ii_line_buffer #(
    .DEPTH  (MAX_WIDTH),
    .II_W   (II_W),
    .IISQ_W (IISQ_W)
  ) u_line_buffer (
    .clock   (clock),
    .wr_en   (accept),
    .addr    (col_q[AW-1:0]),
    .wr_ii   (ii_next),
    .wr_iisq (iisq_next),
    .rd_ii   (lb_ii),
    .rd_iisq (lb_iisq)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      width_q   <= 16'd0;
      height_q  <= 16'd0;
      sq_q      <= 1'b0;
      col_q     <= 16'd0;
      row_q     <= 16'd0;
      row_sum_q <= '0;
      row_sq_q  <= '0;
      out_valid <= 1'b0;
      out_ii    <= '0;
      out_iisq  <= '0;
      out_row   <= 16'd0;
      out_col   <= 16'd0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_ii    <= ii_next;
        out_iisq  <= iisq_next;
        out_row   <= row_q;
        out_col   <= col_q;
        out_sof   <= (row_q == 16'd0) && (col_q == 16'd0);
        out_eol   <= last_col;
        out_eof   <= last_col && last_row;
        row_sum_q <= row_sum_next;
        row_sq_q  <= row_sq_next;

        if (state == ST_IDLE) begin
          width_q  <= cfg_width;
          height_q <= cfg_height;
          sq_q     <= sq_en;
          state    <= ST_RUN;
          busy     <= 1'b1;
        end

        // A frame-ending pixel overrides the start above, so a 1x1 frame
        // goes straight back to idle.
        if (last_col) begin
          col_q <= 16'd0;
          if (last_row) begin
            row_q <= 16'd0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            row_q <= row_q + 16'd1;
          end
        end else begin
          col_q <= col_q + 16'd1;
        end
      end else if (out_ready) begin
        // Entry drained with nothing new: markers drop with valid, data holds.
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eol   <= 1'b0;
        out_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_int_img_calc.sv
// tb/tb_stream_int_img_calc.sv - self-checking bench for stream_int_img_calc
module tb_stream_int_img_calc;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cfg_width;
  logic [15:0] cfg_height;
  logic        sq_en;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pix;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_ii;
  logic [32:0] out_iisq;
  logic [15:0] out_row;
  logic [15:0] out_col;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;
  logic        busy;
  logic        cfg_err;

  stream_int_img_calc dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .sq_en      (sq_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pix     (in_pix),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ii     (out_ii),
    .out_iisq   (out_iisq),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  typedef struct {
    logic [24:0] ii;
    logic [32:0] iisq;
    logic [15:0] row;
    logic [15:0] col;
    logic        sof;
    logic        eol;
    logic        eof;
    logic        busy;
    int          cyc;
  } cap_t;

  typedef struct {
    int          row;
    int          col;
    logic [24:0] ii;
    logic [32:0] iisq;
    logic        sof;
    logic        eol;
    logic        eof;
  } vec_t;

  cap_t       cap_q[$];
  vec_t       exp_q[$];
  logic [7:0] pix_q[$];
  logic       rdy_pat[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic set_cfg(input int w, input int h, input logic sq);
    cfg_width  = 16'(w);
    cfg_height = 16'(h);
    sq_en      = sq;
  endtask

  function automatic void add_exp(input int r, input int c, input longint ii, input longint iisq,
                                  input logic sof, input logic eol, input logic eof);
    vec_t v;
    v.row = r; v.col = c; v.ii = 25'(ii); v.iisq = 33'(iisq);
    v.sof = sof; v.eol = eol; v.eof = eof;
    exp_q.push_back(v);
  endfunction

  // Streams pix_q[0..n-1] through the block, capturing every drained output.
  // After pixel sw is accepted the config switches to (w2,h2,sq2).
  task automatic run_stream(input int n, input int sw, input int w2, input int h2,
                            input logic sq2, input int max_cyc);
    int   idx = 0;
    int   k = 0;
    int   cyc = 0;
    logic held = 1'b0;
    logic pend = 1'b0;
    logic [81:0] snap, prev;
    cap_t c;
    cap_q.delete();
    prev = '0;
    while ((idx < n || out_valid) && cyc < max_cyc) begin
      @(posedge clock); #1;
      if (pend) begin set_cfg(w2, h2, sq2); pend = 1'b0; end
      out_ready = (rdy_pat.size() == 0) ? 1'b1 : rdy_pat[k % rdy_pat.size()];
      in_valid  = (idx < n);
      in_pix    = (idx < n) ? pix_q[idx] : 8'd0;
      @(negedge clock);
      snap = {out_ii, out_iisq, out_row, out_col, out_sof, out_eol, out_eof, out_valid};
      if (held) begin
        checks++;
        if (snap != prev) begin
          errors++;
          $display("FAIL hold_stable: got %h, want %h", snap, prev);
        end
      end
      if (out_valid && out_ready) begin
        c.ii = out_ii; c.iisq = out_iisq; c.row = out_row; c.col = out_col;
        c.sof = out_sof; c.eol = out_eol; c.eof = out_eof; c.busy = busy; c.cyc = cycle;
        cap_q.push_back(c);
      end
      held = out_valid && !out_ready;
      prev = snap;
      if (in_valid && in_ready) begin
        if (idx == sw) pend = 1'b1;
        idx++;
      end
      k++;
      cyc++;
    end
    @(posedge clock); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (cyc >= max_cyc) begin
      errors++;
      $display("FAIL stream_timeout: got %0d cycles, want < %0d", cyc, max_cyc);
    end
  endtask

  task automatic check_caps(input string name);
    check({name, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i].ii != exp_q[i].ii || cap_q[i].iisq != exp_q[i].iisq ||
          int'(cap_q[i].row) != exp_q[i].row || int'(cap_q[i].col) != exp_q[i].col ||
          cap_q[i].sof != exp_q[i].sof || cap_q[i].eol != exp_q[i].eol ||
          cap_q[i].eof != exp_q[i].eof) begin
        errors++;
        $display("FAIL %s[%0d]: got ii=%0d iisq=%0d rc=%0d,%0d sof/eol/eof=%b%b%b, want ii=%0d iisq=%0d rc=%0d,%0d sof/eol/eof=%b%b%b",
                 name, i, cap_q[i].ii, cap_q[i].iisq, cap_q[i].row, cap_q[i].col,
                 cap_q[i].sof, cap_q[i].eol, cap_q[i].eof,
                 exp_q[i].ii, exp_q[i].iisq, exp_q[i].row, exp_q[i].col,
                 exp_q[i].sof, exp_q[i].eol, exp_q[i].eof);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    int n;
    longint s, sq;
    int eol_cnt;

    reset = 1'b1; in_valid = 1'b0; in_pix = 8'd0; out_ready = 1'b1;
    set_cfg(3, 2, 1'b1);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_outputs", {out_ii, out_iisq, out_row, out_col, out_sof, out_eol, out_eof, cfg_err}, 0);
    @(negedge clock); reset = 1'b0; #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_cfg_err", cfg_err, 0);

    // 3x2 frame of ones
    pix_q = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    add_exp(0, 0, 1, 1, 1, 0, 0);
    add_exp(0, 1, 2, 2, 0, 0, 0);
    add_exp(0, 2, 3, 3, 0, 1, 0);
    add_exp(1, 0, 2, 2, 0, 0, 0);
    add_exp(1, 1, 4, 4, 0, 0, 0);
    add_exp(1, 2, 6, 6, 0, 1, 1);
    run_stream(6, -1, 0, 0, 1'b0, 100);
    check("f3x2_busy_before_eof", cap_q.size() == 6 ? cap_q[4].busy : 1'bx, 1);
    check("f3x2_busy_at_eof", cap_q.size() == 6 ? cap_q[5].busy : 1'bx, 0);
    check_caps("f3x2");

    // 4x4 ramp with stalling downstream
    set_cfg(4, 4, 1'b1);
    pix_q.delete();
    for (int i = 0; i < 16; i++) pix_q.push_back(8'(i));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0; sq = 0;
        for (int i = 0; i <= r; i++)
          for (int j = 0; j <= c; j++) begin
            s  += 4 * i + j;
            sq += (4 * i + j) * (4 * i + j);
          end
        add_exp(r, c, s, sq, r == 0 && c == 0, c == 3, r == 3 && c == 3);
      end
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_stream(16, -1, 0, 0, 1'b0, 200);
    rdy_pat.delete();
    check("ramp_ii_3_3", cap_q.size() == 16 ? longint'(cap_q[15].ii) : -1, 120);
    check_caps("ramp4x4");

    // Invalid configs block input
    in_valid = 1'b1; in_pix = 8'd9;
    set_cfg(0, 2, 1'b1);
    repeat (3) @(negedge clock);
    check("cfg_w0_err", cfg_err, 1);
    check("cfg_w0_ready", in_ready, 0);
    set_cfg(321, 2, 1'b1);
    repeat (3) @(negedge clock);
    check("cfg_w321_err", cfg_err, 1);
    check("cfg_w321_ready", in_ready, 0);
    set_cfg(2, 241, 1'b1);
    repeat (3) @(negedge clock);
    check("cfg_h241_err", cfg_err, 1);
    check("cfg_no_accept", out_valid, 0);
    in_valid = 1'b0;
    set_cfg(2, 2, 1'b1);
    #1;
    check("cfg_2x2_err", cfg_err, 0);
    check("cfg_2x2_ready", in_ready, 1);
    pix_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    add_exp(0, 0, 1, 1, 1, 0, 0);
    add_exp(0, 1, 3, 5, 0, 1, 0);
    add_exp(1, 0, 4, 10, 0, 0, 0);
    add_exp(1, 1, 10, 30, 0, 1, 1);
    run_stream(4, -1, 0, 0, 1'b0, 100);
    check_caps("cfg2x2");

    // Reset in the middle of a 4x4 frame
    set_cfg(4, 4, 1'b1);
    pix_q = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
    run_stream(5, -1, 0, 0, 1'b0, 100);
    check("pre_reset_busy", busy, 1);
    @(negedge clock); reset = 1'b1; #1;
    check("midreset_outputs", {out_valid, out_ii, out_iisq, out_row, out_col, busy, in_ready}, 0);
    @(negedge clock); reset = 1'b0;
    set_cfg(2, 2, 1'b1);
    pix_q = '{8'd2, 8'd2, 8'd2, 8'd2};
    add_exp(0, 0, 2, 4, 1, 0, 0);
    add_exp(0, 1, 4, 8, 0, 1, 0);
    add_exp(1, 0, 4, 8, 0, 0, 0);
    add_exp(1, 1, 8, 16, 0, 1, 1);
    run_stream(4, -1, 0, 0, 1'b0, 100);
    check_caps("post_reset");

    // Back-to-back 2x2 (sq on) then 3x1 (sq off); config changes mid-frame
    set_cfg(2, 2, 1'b1);
    pix_q = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    add_exp(0, 0, 1, 1, 1, 0, 0);
    add_exp(0, 1, 2, 2, 0, 1, 0);
    add_exp(1, 0, 2, 2, 0, 0, 0);
    add_exp(1, 1, 4, 4, 0, 1, 1);
    add_exp(0, 0, 1, 0, 1, 0, 0);
    add_exp(0, 1, 2, 0, 0, 0, 0);
    add_exp(0, 2, 3, 0, 0, 1, 1);
    run_stream(7, 0, 3, 1, 1'b0, 100);
    check("b2b_no_gap", cap_q.size() == 7 ? cap_q[6].cyc - cap_q[0].cyc : -1, 6);
    check_caps("b2b");

    // Width-1 frame: every output is end of line
    set_cfg(1, 2, 1'b1);
    pix_q = '{8'd5, 8'd6};
    add_exp(0, 0, 5, 25, 1, 1, 0);
    add_exp(1, 0, 11, 61, 0, 1, 1);
    run_stream(2, -1, 0, 0, 1'b0, 100);
    check_caps("w1");

    // Full 320x240 frame of 255
    set_cfg(320, 240, 1'b1);
    n = 320 * 240;
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(8'd255);
    run_stream(n, -1, 0, 0, 1'b0, 80000);
    check("big_count", cap_q.size(), n);
    if (cap_q.size() == n) begin
      eol_cnt = 0;
      foreach (cap_q[i]) if (cap_q[i].eol) eol_cnt++;
      check("big_ii_0_319", cap_q[319].ii, 81600);
      check("big_ii_1_0", cap_q[320].ii, 510);
      check("big_final_ii", cap_q[n-1].ii, 64'd19584000);
      check("big_final_iisq", cap_q[n-1].iisq, 64'd4993920000);
      check("big_eof", cap_q[n-1].eof, 1);
      check("big_busy_before", cap_q[n-2].busy, 1);
      check("big_busy_at_eof", cap_q[n-1].busy, 0);
      check("big_eol_count", eol_cnt, 240);
      check("big_throughput", cap_q[n-1].cyc - cap_q[0].cyc, n - 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
